// File: rtl/mean_filter_pkg.sv
// Shared types and constants for the mean-filter front end: aligner state
// encoding, err_pulse bit positions and a counter-width helper.
package mean_filter_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    PAD      = 2'd2,
    DROP     = 2'd3
  } align_state_t;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_SOF   = 2;

  // Bits needed to hold positions 0..n-1; never narrower than one bit.
  function automatic int frame_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI4-Stream register slice: one beat of storage, latency 1,
// payload held stable while m_valid is high and m_ready is low.
module axis_reg_slice #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Room exists when empty or when the held beat leaves on this edge.
  assign s_ready = !valid_q || m_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (s_ready) begin
      valid_d = s_valid;
      if (s_valid) data_d = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;

endmodule

// File: rtl/axis_frame_aligner.sv
// Forces raw AXI4-Stream video into exact FRAME_WIDTH x FRAME_HEIGHT frames.
// Define AXIS_FRAME_ALIGNER_STATS_EN to add saturating frame/error counters.
//
// Handshake: a beat transfers on a rising edge where tvalid && tready; once
// m_axis_tvalid rises, payload is held until m_axis_tready accepts it, and
// s_axis_tready may drop on an input SOF that must wait for padding to finish.
module axis_frame_aligner
  import mean_filter_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  locked,
  output logic [2:0]            err_pulse,
  output logic [1:0]            dbg_state
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int HW = frame_cnt_width(FRAME_WIDTH);
  localparam int VW = frame_cnt_width(FRAME_HEIGHT);
  localparam logic [HW-1:0] H_LAST = HW'(FRAME_WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_HEIGHT - 1);

  align_state_t          state_q, state_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  logic [DATA_WIDTH-1:0] last_pix_q, last_pix_d;
  logic [2:0]            err_q, err_d;
  logic                  pad_frame_q, pad_frame_d;

  logic                  can_acc;
  logic                  emit;
  logic                  fwd;
  logic [DATA_WIDTH-1:0] emit_data;
  logic                  at_origin, at_eol, at_eof;
  logic [DATA_WIDTH+1:0] slice_out;

  // hcnt/vcnt name the position of the next beat handed to the slice.
  assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);
  assign at_eol    = (hcnt_q == H_LAST);
  assign at_eof    = at_eol && (vcnt_q == V_LAST);

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    last_pix_d    = last_pix_q;
    pad_frame_d   = pad_frame_q;
    err_d         = '0;
    s_axis_tready = 1'b0;
    emit          = 1'b0;
    fwd           = 1'b0;
    emit_data     = s_axis_tdata;

    case (state_q)
      WAIT_SOF: begin
        s_axis_tready = can_acc;
        if (s_axis_tvalid && can_acc && s_axis_tuser) begin
          emit    = 1'b1;
          fwd     = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (s_axis_tvalid && s_axis_tuser && !at_origin) begin
          err_d[ERR_SOF] = 1'b1;
          pad_frame_d    = 1'b1;
          state_d        = PAD;
        end else begin
          s_axis_tready = can_acc;
          if (s_axis_tvalid && can_acc) begin
            if (at_origin && !s_axis_tuser) begin
              state_d = WAIT_SOF;
            end else begin
              emit = 1'b1;
              fwd  = 1'b1;
            end
          end
        end
      end
      PAD: begin
        if (can_acc) begin
          emit      = 1'b1;
          emit_data = last_pix_q;
          if (pad_frame_q ? at_eof : at_eol) state_d = ACTIVE;
        end
      end
      DROP: begin
        // An SOF landing exactly on a frame boundary is legitimate, not early.
        if (s_axis_tvalid && s_axis_tuser) begin
          if (at_origin) begin
            state_d = ACTIVE;
          end else begin
            err_d[ERR_SOF] = 1'b1;
            pad_frame_d    = 1'b1;
            state_d        = PAD;
          end
        end else begin
          s_axis_tready = can_acc;
          if (s_axis_tvalid && can_acc && s_axis_tlast) state_d = ACTIVE;
        end
      end
    endcase

    if (fwd) begin
      last_pix_d = s_axis_tdata;
      if (s_axis_tlast && !at_eol) begin
        err_d[ERR_SHORT] = 1'b1;
        pad_frame_d      = 1'b0;
        state_d          = PAD;
      end else if (!s_axis_tlast && at_eol) begin
        err_d[ERR_LONG] = 1'b1;
        state_d         = DROP;
      end
    end

    if (emit) begin
      if (at_eol) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_SOF;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      last_pix_q  <= '0;
      pad_frame_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      last_pix_q  <= last_pix_d;
      pad_frame_q <= pad_frame_d;
      err_q       <= err_d;
    end
  end

  axis_reg_slice #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_slice (
    .clk    (clk),
    .rst    (rst),
    .s_data ({at_origin, at_eol, emit_data}),
    .s_valid(emit),
    .s_ready(can_acc),
    .m_data (slice_out),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

  assign m_axis_tuser = slice_out[DATA_WIDTH+1];
  assign m_axis_tlast = slice_out[DATA_WIDTH];
  assign m_axis_tdata = slice_out[DATA_WIDTH-1:0];
  assign locked       = (state_q != WAIT_SOF);
  assign err_pulse    = err_q;
  assign dbg_state    = state_q;

`ifdef AXIS_FRAME_ALIGNER_STATS_EN
  logic        eof_held_q, eof_held_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // eof_held_q tags the beat sitting in the slice as the last of its frame.
  always_comb begin
    eof_held_d  = eof_held_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (emit) eof_held_d = at_eof;
    if (m_axis_tvalid && m_axis_tready && eof_held_q && (frame_cnt_q != 16'hFFFF))
      frame_cnt_d = frame_cnt_q + 16'd1;
    if ((err_q != '0) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eof_held_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      eof_held_q  <= eof_held_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_axis_frame_aligner.sv
// Directed bench for axis_frame_aligner with an 8x4 frame: clean, junk,
// short/long line, early SOF, random backpressure and mid-frame reset.
module tb_axis_frame_aligner;
  import mean_filter_pkg::*;

  localparam int DW = 8;
  localparam int FW = 8;
  localparam int FH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tuser;
  logic          m_tready = 1'b1;
  logic          locked;
  logic [2:0]    err_pulse;
  logic [1:0]    dbg_state;
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW+1:0] exp_q[$];
  int            exp_pos = 0;
  bit            sb_en = 1'b1;
  bit            rand_rdy = 1'b0;
  int            err_seen[3] = '{0, 0, 0};
  int            rdy_low = 0;
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_beat = '0;

  axis_frame_aligner #(
    .DATA_WIDTH  (DW),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .dbg_state    (dbg_state)
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // random backpressure, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  end

  // monitor + scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) if (err_pulse[k]) err_seen[k]++;
      if (s_tvalid && !s_tready) rdy_low++;
      if (prev_stall && m_tvalid) check("stall_hold", {m_tuser, m_tlast, m_tdata}, prev_beat);
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tuser, m_tlast, m_tdata};
      if (m_tvalid && m_tready && sb_en) begin
        check("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("beat", {m_tuser, m_tlast, m_tdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
    logic ok;
    int   n;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accepted", ok, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic send_line(input logic [DW-1:0] base, input int n, input logic sof, input logic last);
    for (int i = 0; i < n; i++)
      send(base + DW'(i), sof && (i == 0), last && (i == n - 1));
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_px(input logic [DW-1:0] d);
    exp_q.push_back({exp_pos == 0, (exp_pos % FW) == FW - 1, d});
    exp_pos = (exp_pos + 1) % (FW * FH);
  endtask

  task automatic exp_run(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_px(base + DW'(i));
  endtask

  task automatic exp_rep(input logic [DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) exp_px(d);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err_pulse, 0);
    check("rst_state", dbg_state, WAIT_SOF);
    rst = 1'b0;

    // junk before SOF, then a clean frame 0..31
    send(8'hEE, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b1);
    send(8'h12, 1'b0, 1'b0);
    check("junk_no_out", m_tvalid, 0);
    check("junk_unlocked", locked, 0);
    exp_run(8'h00, 32);
    send(8'h00, 1'b1, 1'b0);
    check("lat_valid", m_tvalid, 1);
    check("lat_data", m_tdata, 8'h00);
    check("lat_tuser", m_tuser, 1);
    check("lat_locked", locked, 1);
    for (int i = 1; i < 32; i++) send(DW'(i), 1'b0, (i % FW) == FW - 1);
    drain();
    check("clean_err_short", err_seen[ERR_SHORT], 0);
    check("clean_err_long", err_seen[ERR_LONG], 0);
    check("clean_err_sof", err_seen[ERR_SOF], 0);

    // line 1 ends after 5 pixels (last 0x2C)
    rdy_low = 0;
    exp_run(8'h20, 8);
    exp_run(8'h28, 5);
    exp_rep(8'h2C, 3);
    exp_run(8'h30, 8);
    exp_run(8'h38, 8);
    send_line(8'h20, 8, 1'b1, 1'b1);
    send_line(8'h28, 5, 1'b0, 1'b1);
    send_line(8'h30, 8, 1'b0, 1'b1);
    send_line(8'h38, 8, 1'b0, 1'b1);
    drain();
    check("short_err_short", err_seen[ERR_SHORT], 1);
    check("short_ready_low", rdy_low, 3);

    // line 2 carries 11 pixels
    rdy_low = 0;
    exp_run(8'h40, 8);
    exp_run(8'h48, 8);
    exp_run(8'h50, 8);
    exp_run(8'h60, 8);
    send_line(8'h40, 8, 1'b1, 1'b1);
    send_line(8'h48, 8, 1'b0, 1'b1);
    send_line(8'h50, 11, 1'b0, 1'b1);
    send_line(8'h60, 8, 1'b0, 1'b1);
    drain();
    check("long_err_long", err_seen[ERR_LONG], 1);
    check("long_err_short", err_seen[ERR_SHORT], 1);
    check("long_ready_low", rdy_low, 0);

    // SOF arrives at (2,4): 12 pad beats, then the held SOF starts a frame
    rdy_low = 0;
    exp_run(8'h70, 8);
    exp_run(8'h78, 8);
    exp_run(8'h80, 4);
    exp_rep(8'h83, 12);
    exp_run(8'h90, 32);
    send_line(8'h70, 8, 1'b1, 1'b1);
    send_line(8'h78, 8, 1'b0, 1'b1);
    send_line(8'h80, 4, 1'b0, 1'b0);
    send(8'h90, 1'b1, 1'b0);
    check("sof_held_tuser", m_tuser, 1);
    check("sof_held_data", m_tdata, 8'h90);
    check("sof_ready_low", rdy_low, 13);
    for (int i = 1; i < 32; i++) send(8'h90 + DW'(i), 1'b0, (i % FW) == FW - 1);
    drain();
    check("sof_err_sof", err_seen[ERR_SOF], 1);

    // random backpressure: short line, long last line, clean frame
    rand_rdy = 1'b1;
    exp_run(8'hB0, 3);
    exp_rep(8'hB2, 5);
    exp_run(8'hB8, 24);
    exp_run(8'hD0, 32);
    exp_run(8'h10, 32);
    send_line(8'hB0, 3, 1'b1, 1'b1);
    send_line(8'hB8, 8, 1'b0, 1'b1);
    send_line(8'hC0, 8, 1'b0, 1'b1);
    send_line(8'hC8, 8, 1'b0, 1'b1);
    send_line(8'hD0, 8, 1'b1, 1'b1);
    send_line(8'hD8, 8, 1'b0, 1'b1);
    send_line(8'hE0, 8, 1'b0, 1'b1);
    send_line(8'hE8, 9, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) send(8'h10 + DW'(i), i == 0, (i % FW) == FW - 1);
    drain();
    check("rand_err_short", err_seen[ERR_SHORT], 2);
    check("rand_err_long", err_seen[ERR_LONG], 2);
    check("rand_err_sof", err_seen[ERR_SOF], 1);

    // reset mid-frame with a beat held in the output slice
    rand_rdy = 1'b0;
    idle(1);
    m_tready = 1'b1;
    sb_en = 1'b0;
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    m_tready = 1'b0;
    idle(1);
    check("pre_rst_valid", m_tvalid, 1);
    check("pre_rst_data", m_tdata, 8'h04);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_state", dbg_state, WAIT_SOF);
    rst = 1'b0;
    m_tready = 1'b1;
    exp_pos = 0;
    sb_en = 1'b1;
    send(8'h77, 1'b0, 1'b0);
    check("post_rst_junk", m_tvalid, 0);
    exp_run(8'h40, 32);
    for (int i = 0; i < 32; i++) send(8'h40 + DW'(i), i == 0, (i % FW) == FW - 1);
    drain();
    check("final_err_short", err_seen[ERR_SHORT], 2);
    check("final_err_long", err_seen[ERR_LONG], 2);
    check("final_err_sof", err_seen[ERR_SOF], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
